sbin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter for driving seven-segment digit decoders from wider datapaths. It replaces the combinational 6-bit signed converter where width, timing closure or digit count outgrow it. It accepts a two's-complement or unsigned word on a start strobe. It runs one shift-add-3 (double-dabble) step per clock and presents sign plus packed BCD digits with a one-cycle done pulse.

---
 rtl/sbin_to_bcd_seq.sv | 118 +++++++++++
 tb/tb_sbin_to_bcd_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one step per clock).
// Optional saturation on overflow: define SBIN_TO_BCD_SAT_EN.
module sbin_to_bcd_seq #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    dig;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    next_dig;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             capture_neg;

  assign capture_neg = (SIGNED != 0) && binary[WIDTH-1];

`ifdef SBIN_TO_BCD_SAT_EN
  logic sticky;
  logic carry_out;

  // A 1 leaving the top digit means the value needs more than DIGITS digits.
  assign carry_out = adj[BW-1];
`else
  assign ovf = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    adj = dig;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig[4*i +: 4] > 4'd4) adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
    end
    next_dig = (adj << 1) | {{(BW-1){1'b0}}, mag[WIDTH-1]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      dig   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sign  <= 1'b0;
      bcd   <= '0;
`ifdef SBIN_TO_BCD_SAT_EN
      sticky <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Unsigned WIDTH-bit negation, so the most negative input still fits.
            mag   <= capture_neg ? -binary : binary;
            neg   <= capture_neg;
            dig   <= '0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CONV;
`ifdef SBIN_TO_BCD_SAT_EN
            sticky <= 1'b0;
`endif
          end
        end
        CONV: begin
          dig <= next_dig;
          mag <= mag << 1;
          cnt <= cnt - 1'b1;
`ifdef SBIN_TO_BCD_SAT_EN
          sticky <= sticky | carry_out;
`endif
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sign  <= neg;
`ifdef SBIN_TO_BCD_SAT_EN
            if (sticky | carry_out) begin
              ovf <= 1'b1;
              bcd <= {DIGITS{4'h9}};
            end else begin
              ovf <= 1'b0;
              bcd <= next_dig;
            end
`else
            bcd <= next_dig;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbin_to_bcd_seq.sv
// Directed and sweep bench for sbin_to_bcd_seq over three parameter sets;
// expectations adapt to whether SBIN_TO_BCD_SAT_EN is defined.
module tb_sbin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance 0: default parameters (6 bits, 2 digits, signed).
  logic       start0 = 1'b0;
  logic [5:0] bin0 = '0;
  logic       busy0, done0, sign0, ovf0;
  logic [7:0] bcd0;

  // Instance 1: 8 bits, 2 digits, unsigned.
  logic       start1 = 1'b0;
  logic [7:0] bin1 = '0;
  logic       busy1, done1, sign1, ovf1;
  logic [7:0] bcd1;

  // Instance 2: 10 bits, 3 digits, signed.
  logic        start2 = 1'b0;
  logic [9:0]  bin2 = '0;
  logic        busy2, done2, sign2, ovf2;
  logic [11:0] bcd2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sbin_to_bcd_seq u0 (
    .clk(clk), .rst(rst), .start(start0), .binary(bin0),
    .busy(busy0), .done(done0), .sign(sign0), .bcd(bcd0), .ovf(ovf0)
  );

  sbin_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .binary(bin1),
    .busy(busy1), .done(done1), .sign(sign1), .bcd(bcd1), .ovf(ovf1)
  );

  sbin_to_bcd_seq #(.WIDTH(10), .DIGITS(3), .SIGNED(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .binary(bin2),
    .busy(busy2), .done(done2), .sign(sign2), .bcd(bcd2), .ovf(ovf2)
  );

  // Result word per instance: {ovf, sign, 12-bit bcd}.
  logic [13:0] res_w [3];
  logic        busy_w [3];
  logic        done_w [3];

  assign res_w[0]  = {ovf0, sign0, 4'h0, bcd0};
  assign res_w[1]  = {ovf1, sign1, 4'h0, bcd1};
  assign res_w[2]  = {ovf2, sign2, bcd2};
  assign busy_w[0] = busy0;
  assign busy_w[1] = busy1;
  assign busy_w[2] = busy2;
  assign done_w[0] = done0;
  assign done_w[1] = done1;
  assign done_w[2] = done2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sign, then magnitude mod 10^digits (or all nines when saturating).
  function automatic logic [13:0] model(input int width, input int digits,
                                        input bit signed_mode, input int val);
    int  v, mag, pow, m, b;
    bit  s, o;
    v   = val & ((1 << width) - 1);
    s   = signed_mode && (((v >> (width - 1)) & 1) == 1);
    mag = s ? (1 << width) - v : v;
    pow = 1;
    for (int i = 0; i < digits; i++) pow *= 10;
    o = 1'b0;
    b = 0;
    m = mag % pow;
`ifdef SBIN_TO_BCD_SAT_EN
    if (mag >= pow) begin
      o = 1'b1;
      m = pow - 1;
    end
`endif
    for (int d = 0; d < digits; d++) begin
      b = b | ((m % 10) << (4 * d));
      m = m / 10;
    end
    return {o, s, b[11:0]};
  endfunction

  task automatic drive(input int which, input logic s, input int val);
    case (which)
      0: begin start0 = s; bin0 = val[5:0]; end
      1: begin start1 = s; bin1 = val[7:0]; end
      default: begin start2 = s; bin2 = val[9:0]; end
    endcase
  endtask

  // One start pulse, then wait (bounded) for done; reports result and busy-cycle count.
  task automatic convert(input int which, input int val, output logic [13:0] res,
                         output int busy_cycles);
    logic got;
    got = 1'b0;
    busy_cycles = 0;
    @(negedge clk);
    drive(which, 1'b1, val);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (k == 0) drive(which, 1'b0, val);
      if (done_w[which]) got = 1'b1;
      else if (busy_w[which]) busy_cycles++;
    end
    check($sformatf("done_seen_%0d_%0d", which, val), {31'd0, got}, 32'd1);
    res = res_w[which];
  endtask

  initial begin
    logic [13:0] res;
    int          bc;
    int          cyc, since, last_done, n_done, spacing;
    int          seq [3];
    logic        any_done;

    seq[0] = 5;
    seq[1] = -7;
    seq[2] = 12;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {27'd0, busy0, done0, res_w[0]}, 32'd0);

    // 31: busy exactly WIDTH cycles, done for one cycle only, outputs held.
    convert(0, 31, res, bc);
    check("busy_cycles_31", bc, 32'd6);
    check("result_31", res, 14'h0031);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done0}, 32'd0);
    check("result_held", res_w[0], 14'h0031);

    convert(0, 32, res, bc);
    check("result_most_neg", res, 14'h1032);
    convert(0, 63, res, bc);
    check("result_minus1", res, 14'h1001);
    convert(0, 0, res, bc);
    check("result_zero", res, 14'h0000);

    // start held high: back-to-back conversions, mid-conversion input noise.
    @(negedge clk);
    drive(0, 1'b1, seq[0]);
    cyc = 0; since = 0; last_done = 0; n_done = 0;
    for (int k = 0; k < 60 && n_done < 3; k++) begin
      @(negedge clk);
      cyc++;
      since++;
      if (since == 3) drive(0, 1'b1, 21);
      if (done0) begin
        check($sformatf("held_start_result_%0d", n_done), res_w[0], model(6, 2, 1'b1, seq[n_done]));
        if (n_done > 0) begin
          spacing = cyc - last_done;
          check($sformatf("pulse_spacing_%0d", n_done), spacing, 32'd7);
        end
        last_done = cyc;
        since = 0;
        n_done++;
        if (n_done < 3) drive(0, 1'b1, seq[n_done]);
        else drive(0, 1'b0, 0);
      end
    end
    drive(0, 1'b0, 0);
    check("held_start_pulses", n_done, 32'd3);

    // Reset three cycles into a conversion of 27.
    @(negedge clk);
    drive(0, 1'b1, 27);
    @(negedge clk);
    drive(0, 1'b0, 27);
    repeat (2) @(negedge clk);
    check("busy_before_reset", {31'd0, busy0}, 32'd1);
    check("hold_during_conv", res_w[0], model(6, 2, 1'b1, 12));
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {27'd0, busy0, done0, res_w[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    any_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_done = any_done | done0;
    end
    check("no_done_after_reset", {31'd0, any_done}, 32'd0);
    convert(0, 27, res, bc);
    check("result_27_after_reset", res, 14'h0027);

    // Overflow boundary on the unsigned 8-bit instance.
    convert(1, 200, res, bc);
`ifdef SBIN_TO_BCD_SAT_EN
    check("u8_200", res, 14'h2099);
`else
    check("u8_200", res, 14'h0000);
`endif
    check("u8_busy_cycles", bc, 32'd8);
    convert(1, 99, res, bc);
    check("u8_99", res, 14'h0099);
    convert(1, 255, res, bc);
    check("u8_255", res, model(8, 2, 1'b0, 255));

    // Exhaustive sweeps.
    for (int v = 0; v < 64; v++) begin
      convert(0, v, res, bc);
      check($sformatf("sweep6_%0d", v), res, model(6, 2, 1'b1, v));
    end
    for (int v = 0; v < 1024; v++) begin
      convert(2, v, res, bc);
      check($sformatf("sweep10_%0d", v), res, model(10, 3, 1'b1, v));
    end
    check("u10_busy_cycles", bc, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
